// File: rtl/pe_pkg.sv
// Shared types and default sizing for the PE operand feeder.
package pe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } feeder_state_t;

   localparam int PE_DATA_WIDTH = 8;
   localparam int PE_NUM        = 4;

endpackage

// File: rtl/pe_skid_fifo.sv
// Two-entry FIFO that absorbs buffer read latency against PE-array backpressure.
module pe_skid_fifo #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       occupancy
);

   logic [1:0][WIDTH-1:0] mem;
   logic                  wr_ptr;
   logic                  rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem       <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 2'd1;
            2'b01:   occupancy <= occupancy - 2'd1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/pe_operand_feeder.sv
// Reads paired weight/activation vectors from the operand buffers and streams
// them to the PE array as valid/ready beats, in address order.
module pe_operand_feeder
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_WIDTH,
   parameter int NUM_PE     = PE_NUM,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_WIDTH-1:0]        w_base,
   input  logic [ADDR_WIDTH-1:0]        x_base,
   input  logic [LEN_WIDTH-1:0]         len,
   output logic                         w_rd_en,
   output logic [ADDR_WIDTH-1:0]        w_rd_addr,
   input  logic [NUM_PE*DATA_WIDTH-1:0] w_rd_data,
   output logic                         x_rd_en,
   output logic [ADDR_WIDTH-1:0]        x_rd_addr,
   input  logic [NUM_PE*DATA_WIDTH-1:0] x_rd_data,
   output logic [NUM_PE*DATA_WIDTH-1:0] w_out,
   output logic [NUM_PE*DATA_WIDTH-1:0] x_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done
);

   localparam int BW = NUM_PE*DATA_WIDTH;
   localparam int FW = 2*BW + 1;
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   feeder_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0]  w_addr_q, x_addr_q;
   logic [LEN_WIDTH-1:0]   len_q, issue_cnt_q;
   logic                   rd_vld_q, rd_last_q;
   logic [1:0]             occ;
   logic [2:0]             credit_sum;
   logic                   pop, issue, last_issue, head_last;
   logic [FW-1:0]          fifo_dout;

   assign pop        = out_valid && out_ready;
   // Entries already committed (queued + in flight) after this cycle's pop.
   assign credit_sum = {1'b0, occ} + {2'b0, rd_vld_q} - {2'b0, pop};
   assign issue      = (state_q == ST_RUN) && (credit_sum < 3'd2);
   assign last_issue = (issue_cnt_q == len_q - LEN_ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (issue && last_issue) state_d = ST_DRAIN;
         ST_DRAIN: if (pop && out_last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_DONE);
      w_rd_en = issue;
      x_rd_en = issue;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_addr_q    <= '0;
         x_addr_q    <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         rd_vld_q    <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && start) begin
            w_addr_q    <= w_base;
            x_addr_q    <= x_base;
            len_q       <= len;
            issue_cnt_q <= '0;
         end else if (issue) begin
            w_addr_q    <= w_addr_q + ADDR_ONE;
            x_addr_q    <= x_addr_q + ADDR_ONE;
            issue_cnt_q <= issue_cnt_q + LEN_ONE;
         end
         // The last flag travels with the read so it lands on the right beat.
         rd_vld_q  <= issue;
         rd_last_q <= issue && last_issue;
      end
   end

   assign w_rd_addr = w_addr_q;
   assign x_rd_addr = x_addr_q;

   pe_skid_fifo #(.WIDTH(FW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_vld_q),
      .din       ({rd_last_q, x_rd_data, w_rd_data}),
      .pop       (pop),
      .dout      (fifo_dout),
      .occupancy (occ)
   );

   assign {head_last, x_out, w_out} = fifo_dout;
   assign out_valid = (occ != 2'd0);
   assign out_last  = out_valid && head_last;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Scoreboard bench for pe_operand_feeder: expected beats and read addresses are
// queued at launch and compared as the DUT issues reads and delivers beats.
module tb_pe_operand_feeder;

   localparam int AW = 10;
   localparam int LW = 10;
   localparam int BW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] w_base = '0, x_base = '0;
   logic [LW-1:0] len = '0;
   logic          w_rd_en, x_rd_en;
   logic [AW-1:0] w_rd_addr, x_rd_addr;
   logic [BW-1:0] w_rd_data = '0, x_rd_data = '0;
   logic [BW-1:0] w_out, x_out;
   logic          out_valid, out_last, busy, done;
   logic          out_ready = 1'b1;

   pe_operand_feeder dut (
      .clk(clk), .rst(rst), .start(start), .w_base(w_base), .x_base(x_base), .len(len),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
      .w_out(w_out), .x_out(x_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          last;
      logic [BW-1:0] x;
      logic [BW-1:0] w;
   } beat_t;

   beat_t          sb[$];
   logic [2*AW-1:0] aq[$];
   int n_chk = 0, n_pass = 0;
   int cyc = 0, start_cyc = 0;
   int mode = 0;
   logic [3:0] pat = 4'b1001;

   int rd_total = 0, beat_total = 0, done_total = 0;
   int rd_rel[int], beat_rel[int];
   int last_rel = 0, done_rel = 0;
   int r0 = 0, b0 = 0, d0 = 0;

   function automatic logic [BW-1:0] fw(input logic [AW-1:0] a);
      return 32'h5A00_0000 ^ ({22'h0, a} * 32'h0001_0101);
   endfunction
   function automatic logic [BW-1:0] fx(input logic [AW-1:0] a);
      return 32'hC300_0000 ^ ({22'h0, a} * 32'h0003_0007);
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   always @(posedge clk) cyc++;

   // Operand buffers: synchronous read, one-cycle latency.
   always @(posedge clk) begin
      if (w_rd_en) w_rd_data <= fw(w_rd_addr);
      if (x_rd_en) x_rd_data <= fx(x_rd_addr);
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[(cyc - start_cyc) & 3];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   int    issued = 0, popped = 0, rel;
   logic  hold_v = 0, prev_done = 0;
   logic [2*BW:0] hold_b;
   beat_t b;
   logic [2*AW-1:0] a;

   always @(negedge clk) begin
      if (rst) begin
         issued = 0; popped = 0; hold_v = 0; prev_done = 0;
      end else begin
         rel = cyc - start_cyc;
         if (hold_v) chk("stall_hold", {out_valid, out_last, x_out, w_out}, {1'b1, hold_b});
         chk("x_en_eq_w_en", x_rd_en, w_rd_en);
         if (w_rd_en) begin
            if (aq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               a = aq.pop_front();
               chk("rd_addr", {x_rd_addr, w_rd_addr}, a);
            end
            rd_rel[rd_total] = rel;
            rd_total++;
            issued++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
               b = sb.pop_front();
               chk("beat", {out_last, x_out, w_out}, b);
            end
            beat_rel[beat_total] = rel;
            if (out_last) last_rel = rel;
            beat_total++;
            popped++;
         end
         if (w_rd_en) chk("credit", (issued - popped) <= 2, 1);
         if (prev_done) chk("busy_after_done", busy, 0);
         if (done) begin
            chk("busy_with_done", busy, 1);
            done_rel = rel;
            done_total++;
         end
         prev_done = done;
         hold_v = out_valid && !out_ready;
         hold_b = {out_last, x_out, w_out};
      end
   end

   task automatic drive_start(input logic [AW-1:0] wb, input logic [AW-1:0] xb, input logic [LW-1:0] l);
      @(negedge clk);
      start = 1'b1; w_base = wb; x_base = xb; len = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic launch(input logic [AW-1:0] wb, input logic [AW-1:0] xb, input logic [LW-1:0] l);
      logic [AW-1:0] wa, xa;
      for (int i = 0; i < int'(l); i++) begin
         wa = wb + AW'(i);
         xa = xb + AW'(i);
         sb.push_back('{last: (i == int'(l) - 1), x: fx(xa), w: fw(wa)});
         aq.push_back({xa, wa});
      end
      r0 = rd_total; b0 = beat_total; d0 = done_total;
      drive_start(wb, xb, l);
      start_cyc = cyc - 1;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (done_total != d0) break;
         @(posedge clk);
      end
      if (done_total == d0) chk({tag, "_timeout"}, 0, 1);
      repeat (3) @(posedge clk);
      chk({tag, "_done_count"}, done_total - d0, 1);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_rd_empty"}, aq.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vals", {w_rd_en, x_rd_en, w_rd_addr, x_rd_addr, w_out, x_out, out_valid, out_last, busy, done}, '0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);

      // Basic timing with continuous ready.
      mode = 0;
      launch(10'h010, 10'h200, 10'd4);
      wait_done("t1");
      chk("t1_first_rd", rd_rel[r0], 1);
      chk("t1_first_beat", beat_rel[b0], 3);
      chk("t1_last_beat", last_rel, 6);
      chk("t1_done", done_rel, 7);
      chk("t1_beats", beat_total - b0, 4);

      // Backpressure pattern.
      mode = 1;
      launch(10'h020, 10'h100, 10'd6);
      wait_done("t2");
      chk("t2_beats", beat_total - b0, 6);
      mode = 0;

      // Zero-length command.
      launch(10'h055, 10'h066, 10'd0);
      wait_done("t3");
      chk("t3_done", done_rel, 1);
      chk("t3_no_reads", rd_total - r0, 0);
      chk("t3_no_beats", beat_total - b0, 0);

      // Address wrap.
      launch(10'h3FE, 10'h005, 10'd4);
      wait_done("t4");
      chk("t4_beats", beat_total - b0, 4);

      // start during RUN is ignored.
      launch(10'h040, 10'h140, 10'd5);
      drive_start(10'h300, 10'h310, 10'd3);
      wait_done("t5");
      chk("t5_beats", beat_total - b0, 5);

      // Random backpressure.
      mode = 2;
      launch(10'h0A0, 10'h2A0, 10'd7);
      wait_done("t6");
      chk("t6_beats", beat_total - b0, 7);
      mode = 0;

      // Reset mid-command, then a fresh command.
      launch(10'h080, 10'h180, 10'd8);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t7_rst_vals", {w_rd_en, x_rd_en, w_rd_addr, x_rd_addr, w_out, x_out, out_valid, out_last, busy, done}, '0);
      sb.delete();
      aq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      launch(10'h0C0, 10'h1C0, 10'd2);
      wait_done("t7");
      chk("t7_beats", beat_total - b0, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pe_operand_feeder.md
# pe_operand_feeder

Streams operand vectors into the PE array. On `start`, it reads `len` consecutive weight words and activation words from the two on-chip operand buffers, which have synchronous read. It pairs each weight word with its activation word and presents them as one `NUM_PE`-lane beat under a valid/ready handshake. The block sits between the weight and activation buffers and the `w`/`x` inputs of the PE array. It absorbs buffer read latency and downstream backpressure without losing or duplicating beats.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one lane operand
- `NUM_PE`, 4, lanes per beat (one per PE)
- `ADDR_WIDTH`, 10, operand buffer address width
- `LEN_WIDTH`, 10, width of the vector-count field

Ports:
- `clk`  in  1  clock. One clock domain; all logic on its rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE
- `w_base`  in  ADDR_WIDTH  first weight address; sampled with `start`
- `x_base`  in  ADDR_WIDTH  first activation address; sampled with `start`
- `len`  in  LEN_WIDTH  number of beats; sampled with `start`
- `w_rd_en`  out  1  weight buffer read strobe
- `w_rd_addr`  out  ADDR_WIDTH  weight buffer address
- `w_rd_data`  in  NUM_PE*DATA_WIDTH  weight data, valid the cycle after `w_rd_en`
- `x_rd_en`  out  1  activation buffer read strobe; always equal to `w_rd_en`
- `x_rd_addr`  out  ADDR_WIDTH  activation buffer address
- `x_rd_data`  in  NUM_PE*DATA_WIDTH  activation data, valid the cycle after `x_rd_en`
- `w_out`  out  NUM_PE*DATA_WIDTH  weight lanes; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH]
- `x_out`  out  NUM_PE*DATA_WIDTH  activation lanes, same packing
- `out_valid`  out  1  beat present
- `out_ready`  in  1  PE array accepts the beat
- `out_last`  out  1  high with the final beat of the command
- `busy`  out  1  high in every state other than IDLE
- `done`  out  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start`, latch the command inputs.
  - If `len`==0, go to DONE. Otherwise go to RUN.
- RUN:
  - Issue one paired read per cycle when credit allows.
  - Credit rule: issue when `occupancy + in_flight - pop < 2`, where `pop` = `out_valid && out_ready`.
  - Each issued read increments both addresses by 1. Addresses wrap modulo 2^ADDR_WIDTH.
  - After the `len`-th read is issued, go to DRAIN.
- DRAIN: stay until the final beat is popped, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Return data is written into a 2-entry FIFO the cycle it arrives. The FIFO head drives `w_out`, `x_out` and `out_valid`.
- `out_last` is high on the beat whose pop count equals `len`-1.
- `start` in any non-IDLE state is ignored. The latched command is not changed.
- Beat order is strictly address order. There is no reordering and no lane swizzle.
- `out_ready` low holds the head beat stable: `w_out`, `x_out`, `out_valid` and `out_last` do not change.
- Reset at any point:
  - Clears the FSM to IDLE, both counters, `in_flight` and FIFO occupancy.
  - Read data returning after reset is discarded.
- Reset values: `w_rd_en`=`x_rd_en`=0, addresses 0, `w_out`=`x_out`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at the edge ending cycle 0. RUN begins in cycle 1, and the first read is issued in cycle 1.
- Read issued in cycle N: data arrives in cycle N+1, is written at the end of N+1, and `out_valid` is high in cycle N+2. First beat therefore appears in cycle 3.
- With `out_ready` held high, throughput is 1 beat per cycle. The last beat appears in cycle `len`+2.
- `done` is high in the cycle after the final pop. `busy` falls in the same cycle `done` falls.
- `len`==0: `done` high in cycle 1. No read strobe is ever asserted.
- A new `start` is accepted in the cycle after `done`.
- FIFO never overflows: the credit rule guarantees `occupancy` ≤ 2.

## Structure
- Shared package `pe_pkg`:
  - FSM state enum `feeder_state_t`.
  - Default constants `PE_DATA_WIDTH`, `PE_NUM`.
- Sub-module `pe_skid_fifo`:
  - 2-entry synchronous FIFO, width 2*NUM_PE*DATA_WIDTH+1 (w, x, last).
  - Ports: push, pop, occupancy.
  - Async active-high reset.

## Test plan
- `len`=4, bases 0x010 / 0x200, `out_ready`=1: reads at 0x010–0x013 and 0x200–0x203 in cycles 1–4; beats in cycles 3–6; `out_last` only in cycle 6; `done` in cycle 7.
- `len`=6 with `out_ready` toggling 1,0,0,1,…: six beats in address order, each held stable while stalled; `occupancy` never exceeds 2; no read issued without credit.
- `len`=0: `done` in cycle 1, `w_rd_en` never asserted, `out_valid` never asserted.
- `w_base`=0x3FE, `len`=4, ADDR_WIDTH=10: `w_rd_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- `start` pulsed in mid-RUN with different `len`: ignored; original beat count delivered and one `done`.
- `rst` asserted in cycle 4 of an 8-beat command: all outputs return to reset values immediately; after release, a fresh `len`=2 command completes correctly with no stale beats.
